obuf_stream_reader: RTL and testbench
=====================================

# obuf_stream_reader

Drains the edge-detector output buffer (the 12-bit output FIFO read port exported by the Sobel top level) and converts the buffered pixels into a framed ready/valid pixel stream for the display/DMA sink. It owns the FIFO read strobe, absorbs the FIFO's one-cycle read latency with a 2-entry skid buffer, and tags each pixel with start-of-frame and end-of-line markers derived from raster counters. The block sits between the Sobel output FIFO and the video output path.

## Interface
- LINE_LENGTH, 640, pixels per line.
- LINE_NUM, 480, lines per frame.
- DW, 12, pixel width, matching the FIFO data width.
- CLK  in  1  clock; all logic on the rising edge.
- RST  in  1  synchronous, active-high reset.
- i_enable  in  1  permits new FIFO reads; data already in flight still drains.
- i_flush  in  1  synchronous frame abort; same effect as RST on this block's state.
- i_obuf_data  in  DW  FIFO read data, valid one cycle after o_obuf_rd.
- i_obuf_empty  in  1  FIFO empty.
- i_obuf_almostempty  in  1  FIFO fill ≤ 1.
- o_obuf_rd  out  1  FIFO read strobe, combinational from registered state.
- o_tdata  out  DW  pixel.
- o_tvalid  out  1  pixel valid.
- i_tready  in  1  sink accepts pixel.
- o_tuser  out  1  start of frame, with pixel (0,0).
- o_tlast  out  1  end of line, with pixel x = LINE_LENGTH-1.
- o_frame_done  out  1  one-cycle pulse after the last pixel of a frame is accepted.

## Operation
- Read issue: o_obuf_rd = i_enable & credit_ok & fifo_ok.
  - credit_ok: skid occupancy + reads in flight < 2.
  - fifo_ok: !i_obuf_almostempty, or (!i_obuf_empty & no read issued the previous cycle). This never reads an empty FIFO with one read outstanding.
- Capture: the data returned the cycle after a read is written into the skid buffer unconditionally. Credit accounting guarantees it is never full at that point.
- Output: the skid head drives o_tdata/o_tvalid. A pop happens on o_tvalid & i_tready.
- Raster counters x (0..LINE_LENGTH-1) and y (0..LINE_NUM-1) advance only on pop.
  - x wraps to 0 at LINE_LENGTH-1 and increments y.
  - y wraps to 0 at LINE_NUM-1. The same pop fires o_frame_done on the next cycle.
- o_tuser = (x==0 & y==0); o_tlast = (x==LINE_LENGTH-1). Both are qualified by o_tvalid.
- FSM states (frame state, used for o_frame_done and debug):
  - IDLE: before the first pop after reset or flush. Goes to STREAM on the first pop.
  - STREAM: goes to FRAME_END on the pop of the last pixel.
  - FRAME_END: lasts 1 cycle, asserts o_frame_done, then returns to STREAM. If o_tvalid & i_tready also occur in this cycle, that pixel is pixel (0,0) of the next frame.
- i_enable low: no new reads; the in-flight read and skid contents still emerge; counters hold between pops.
- RST or i_flush: skid emptied, in-flight read dropped (its data is not captured), counters to 0, FSM to IDLE. The FIFO itself is not flushed by this block.
- Simultaneous capture and pop in the same cycle: occupancy is unchanged and ordering is preserved (FIFO order).

## Timing
- Reset values: o_obuf_rd=0, o_tvalid=0, o_tdata=0, o_tuser=0, o_tlast=0, o_frame_done=0.
- Latency: o_obuf_rd at cycle t, data on i_obuf_data at t+1, o_tvalid with that pixel at t+2.
- Throughput: 1 pixel/cycle sustained while the FIFO has ≥2 entries and i_tready stays high.
- o_tdata, o_tuser and o_tlast are stable while o_tvalid & !i_tready.
- o_tvalid never drops without a pop, except on RST or i_flush.
- o_obuf_rd is never asserted in the cycle RST or i_flush is high.

## Structure
- Shared package sobel_pkg:
  - LINE_LENGTH/LINE_NUM defaults.
  - DW.
  - Counter widths ($clog2 of each).
  - Frame FSM state enum (IDLE, STREAM, FRAME_END).
- One sub-module, stream_skid_buf: 2-entry register FIFO with push, pop, count, head data and a synchronous clear.
- Everything else (credit logic, counters, FSM) is in the top module.

## Test plan
- Reset, then an FIFO preload of 8 pixels 0x010..0x080, i_tready=1 → o_obuf_rd first at cycle 1. o_tdata sequence 0x010..0x080 with no gaps after the first, which appears at cycle 3. o_tuser only on 0x010.
- Full frame with LINE_LENGTH=8, LINE_NUM=4, 32 pixels → o_tlast on pixels 7,15,23,31. o_frame_done pulses once, one cycle after pixel 31 is accepted. Pixel 32 carries o_tuser.
- FIFO holding 1 entry (almostempty=1, empty=0) → exactly one read, no read of an empty FIFO. Pixel emitted, then o_obuf_rd stays 0.
- i_tready held low 10 cycles with a full FIFO → at most 2 reads issued. o_tvalid/o_tdata stay constant. After release, no pixel is lost or duplicated.
- i_flush in the cycle data returns from the FIFO (mid-line, x=5) → that pixel is dropped, o_tvalid=0 next cycle. The next accepted pixel carries o_tuser with x=0,y=0.
- i_enable dropped with 2 pixels in flight/skid → both are delivered, then no reads until i_enable returns. Counters continue from x=2.

Source files
------------

// File: rtl/sobel_pkg.sv
// Shared constants and types for the Sobel output path.
package sobel_pkg;

  localparam int unsigned LINE_LENGTH_DEF = 640;
  localparam int unsigned LINE_NUM_DEF    = 480;
  localparam int unsigned DW_DEF          = 12;
  localparam int unsigned X_W_DEF         = $clog2(LINE_LENGTH_DEF);
  localparam int unsigned Y_W_DEF         = $clog2(LINE_NUM_DEF);

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    FRAME_END
  } frame_state_e;

endpackage

// File: rtl/stream_skid_buf.sv
// Two-entry register FIFO that absorbs the output FIFO's read latency.
module stream_skid_buf #(
  parameter int unsigned DW = 12
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          i_clr,
  input  logic          i_push,
  input  logic [DW-1:0] i_data,
  input  logic          i_pop,
  output logic [1:0]    o_count,
  output logic [DW-1:0] o_head
);

  logic [DW-1:0] mem_q [2];
  logic          wr_ptr_q;
  logic          rd_ptr_q;
  logic [1:0]    count_q;
  logic          pop_ok;
  logic          push_ok;

  assign pop_ok  = i_pop & (count_q != 2'd0);
  // A full buffer still accepts a push when the head leaves in the same cycle.
  assign push_ok = i_push & ((count_q != 2'd2) | pop_ok);

  always_ff @(posedge CLK) begin
    if (RST || i_clr) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= i_data;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop_ok) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_q + {1'b0, push_ok} - {1'b0, pop_ok};
    end
  end

  assign o_count = count_q;
  assign o_head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/obuf_stream_reader.sv
// Drains the Sobel output FIFO into a framed ready/valid pixel stream.
module obuf_stream_reader
  import sobel_pkg::*;
#(
  parameter int unsigned LINE_LENGTH = LINE_LENGTH_DEF,
  parameter int unsigned LINE_NUM    = LINE_NUM_DEF,
  parameter int unsigned DW          = DW_DEF
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          i_enable,
  input  logic          i_flush,
  input  logic [DW-1:0] i_obuf_data,
  input  logic          i_obuf_empty,
  input  logic          i_obuf_almostempty,
  output logic          o_obuf_rd,
  output logic [DW-1:0] o_tdata,
  output logic          o_tvalid,
  input  logic          i_tready,
  output logic          o_tuser,
  output logic          o_tlast,
  output logic          o_frame_done
);

  localparam int unsigned XW = (LINE_LENGTH > 1) ? $clog2(LINE_LENGTH) : 1;
  localparam int unsigned YW = (LINE_NUM > 1) ? $clog2(LINE_NUM) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(LINE_LENGTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(LINE_NUM - 1);

  logic          clr;
  logic          rd_inflight_q;
  logic [1:0]    skid_count;
  logic [DW-1:0] skid_head;
  logic          pop;
  logic [1:0]    credit_use;
  logic          credit_ok;
  logic          fifo_ok;
  logic          frame_last_pop;
  logic [XW-1:0] x_q;
  logic [YW-1:0] y_q;
  frame_state_e  state_q;
  logic          frame_done_q;

  assign clr      = RST | i_flush;
  assign o_tvalid = (skid_count != 2'd0);
  assign pop      = o_tvalid & i_tready;

  // Counting the slot freed by this cycle's pop keeps the stream at one pixel per cycle.
  assign credit_use = skid_count - {1'b0, pop} + {1'b0, rd_inflight_q};
  assign credit_ok  = (credit_use < 2'd2);
  assign fifo_ok    = ~i_obuf_almostempty | (~i_obuf_empty & ~rd_inflight_q);
  assign o_obuf_rd  = i_enable & credit_ok & fifo_ok & ~clr;

  always_ff @(posedge CLK) begin
    if (clr) begin
      rd_inflight_q <= 1'b0;
    end else begin
      rd_inflight_q <= o_obuf_rd;
    end
  end

  stream_skid_buf #(
    .DW (DW)
  ) u_skid (
    .CLK     (CLK),
    .RST     (RST),
    .i_clr   (i_flush),
    .i_push  (rd_inflight_q),
    .i_data  (i_obuf_data),
    .i_pop   (pop),
    .o_count (skid_count),
    .o_head  (skid_head)
  );

  assign frame_last_pop = pop & (x_q == X_LAST) & (y_q == Y_LAST);

  always_ff @(posedge CLK) begin
    if (clr) begin
      x_q          <= '0;
      y_q          <= '0;
      state_q      <= IDLE;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      if (pop) begin
        if (x_q == X_LAST) begin
          x_q <= '0;
          y_q <= (y_q == Y_LAST) ? '0 : y_q + YW'(1);
        end else begin
          x_q <= x_q + XW'(1);
        end
      end
      case (state_q)
        IDLE: begin
          if (frame_last_pop) begin
            state_q      <= FRAME_END;
            frame_done_q <= 1'b1;
          end else if (pop) begin
            state_q <= STREAM;
          end
        end
        STREAM: begin
          if (frame_last_pop) begin
            state_q      <= FRAME_END;
            frame_done_q <= 1'b1;
          end
        end
        FRAME_END: begin
          if (frame_last_pop) begin
            frame_done_q <= 1'b1;
          end else begin
            state_q <= STREAM;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_tdata      = o_tvalid ? skid_head : '0;
  assign o_tuser      = o_tvalid & (x_q == '0) & (y_q == '0);
  assign o_tlast      = o_tvalid & (x_q == X_LAST);
  assign o_frame_done = frame_done_q;

endmodule

// File: tb/tb_obuf_stream_reader.sv
// Scoreboard bench for obuf_stream_reader on an 8x4 frame with a behavioural output FIFO.
module tb_obuf_stream_reader;

  localparam int unsigned LL = 8;
  localparam int unsigned LN = 4;

  typedef struct packed {
    logic [11:0] data;
    logic        tuser;
    logic        tlast;
    logic        fend;
  } exp_t;

  logic        CLK = 1'b0;
  logic        RST;
  logic        i_enable;
  logic        i_flush;
  logic [11:0] i_obuf_data = 12'h000;
  logic        i_obuf_empty;
  logic        i_obuf_almostempty;
  logic        o_obuf_rd;
  logic [11:0] o_tdata;
  logic        o_tvalid;
  logic        i_tready;
  logic        o_tuser;
  logic        o_tlast;
  logic        o_frame_done;

  int          checks = 0;
  int          errors = 0;
  int          rd_count = 0;
  int          fifo_size = 0;
  int          exp_x = 0;
  int          exp_y = 0;
  logic        fd_pend = 1'b0;
  logic [11:0] fifo_q[$];
  logic [11:0] pre_q[$];
  exp_t        sb_q[$];

  always #5 CLK = ~CLK;

  obuf_stream_reader #(
    .LINE_LENGTH (LL),
    .LINE_NUM    (LN),
    .DW          (12)
  ) dut (
    .CLK                (CLK),
    .RST                (RST),
    .i_enable           (i_enable),
    .i_flush            (i_flush),
    .i_obuf_data        (i_obuf_data),
    .i_obuf_empty       (i_obuf_empty),
    .i_obuf_almostempty (i_obuf_almostempty),
    .o_obuf_rd          (o_obuf_rd),
    .o_tdata            (o_tdata),
    .o_tvalid           (o_tvalid),
    .i_tready           (i_tready),
    .o_tuser            (o_tuser),
    .o_tlast            (o_tlast),
    .o_frame_done       (o_frame_done)
  );

  assign i_obuf_empty       = (fifo_size == 0);
  assign i_obuf_almostempty = (fifo_size <= 1);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Output FIFO model: one-cycle read latency, garbage on the bus when not read.
  always @(posedge CLK) begin
    if (o_obuf_rd) begin
      rd_count++;
      checks++;
      if (fifo_q.size() == 0) begin
        errors++;
        $display("FAIL empty_read: read strobe with FIFO empty at %0t", $time);
        i_obuf_data <= 12'hbad;
      end else begin
        i_obuf_data <= fifo_q.pop_front();
      end
    end else begin
      i_obuf_data <= 12'hbad;
    end
    while (pre_q.size() > 0) fifo_q.push_back(pre_q.pop_front());
    fifo_size <= fifo_q.size();
  end

  // Monitor: pops the scoreboard on every accepted pixel, tracks the frame-done pulse.
  always @(negedge CLK) begin
    exp_t e;
    if (!RST) begin
      chk("frame_done", {31'd0, o_frame_done}, {31'd0, fd_pend});
      fd_pend = 1'b0;
      if (o_tvalid && i_tready) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pixel: got 0x%0h, expected none", o_tdata);
        end else begin
          e = sb_q.pop_front();
          chk("tdata", {20'd0, o_tdata}, {20'd0, e.data});
          chk("tuser", {31'd0, o_tuser}, {31'd0, e.tuser});
          chk("tlast", {31'd0, o_tlast}, {31'd0, e.tlast});
          fd_pend = e.fend;
        end
      end
    end
  end

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic push_raw(input logic [11:0] d);
    pre_q.push_back(d);
  endtask

  task automatic push_pix(input logic [11:0] d);
    exp_t e;
    e.data  = d;
    e.tuser = (exp_x == 0) && (exp_y == 0);
    e.tlast = (exp_x == LL - 1);
    e.fend  = (exp_x == LL - 1) && (exp_y == LN - 1);
    sb_q.push_back(e);
    pre_q.push_back(d);
    if (exp_x == LL - 1) begin
      exp_x = 0;
      exp_y = (exp_y == LN - 1) ? 0 : exp_y + 1;
    end else begin
      exp_x++;
    end
  endtask

  task automatic do_flush();
    cyc();
    i_flush = 1'b1;
    @(negedge CLK);
    chk("rd_in_flush", {31'd0, o_obuf_rd}, 32'd0);
    cyc();
    i_flush = 1'b0;
    exp_x = 0;
    exp_y = 0;
  endtask

  task automatic wait_drain(input string name);
    logic ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge CLK);
      if (sb_q.size() == 0 && fifo_q.size() == 0 && pre_q.size() == 0 && !o_tvalid) begin
        ok = 1'b1;
        break;
      end
    end
    chk(name, {31'd0, ok}, 32'd1);
    repeat (2) cyc();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  rd0;
    logic hit;
    RST      = 1'b1;
    i_enable = 1'b1;
    i_flush  = 1'b0;
    i_tready = 1'b1;

    // Preload while in reset; no reads may be issued under reset.
    for (int i = 1; i <= 8; i++) push_pix(12'(i * 16));
    repeat (3) cyc();
    @(negedge CLK);
    chk("rst_rd", {31'd0, o_obuf_rd}, 32'd0);
    chk("rst_tvalid", {31'd0, o_tvalid}, 32'd0);
    chk("rst_tdata", {20'd0, o_tdata}, 32'd0);
    chk("rst_tuser", {31'd0, o_tuser}, 32'd0);
    chk("rst_tlast", {31'd0, o_tlast}, 32'd0);
    chk("rst_frame_done", {31'd0, o_frame_done}, 32'd0);

    // Cycle 1: first read; cycle 3: first pixel.
    cyc();
    RST = 1'b0;
    @(negedge CLK);
    chk("first_rd", {31'd0, o_obuf_rd}, 32'd1);
    @(negedge CLK);
    chk("tvalid_c2", {31'd0, o_tvalid}, 32'd0);
    @(negedge CLK);
    chk("tvalid_c3", {31'd0, o_tvalid}, 32'd1);
    chk("tdata_c3", {20'd0, o_tdata}, 32'h010);
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      chk("no_gap", {31'd0, o_tvalid}, 32'd1);
    end
    wait_drain("drain_preload");

    // Full 8x4 frame plus the first pixel of the next one.
    do_flush();
    for (int i = 0; i < 33; i++) push_pix(12'h200 + 12'(i));
    wait_drain("drain_frame");

    // Single entry: exactly one read, then the strobe stays low.
    do_flush();
    rd0 = rd_count;
    push_pix(12'h3a5);
    repeat (8) cyc();
    @(negedge CLK);
    chk("one_entry_reads", rd_count - rd0, 32'd1);
    chk("one_entry_rd_idle", {31'd0, o_obuf_rd}, 32'd0);
    wait_drain("drain_one");

    // Sink stalled for 10 cycles with plenty of FIFO data.
    do_flush();
    i_tready = 1'b0;
    rd0 = rd_count;
    for (int i = 1; i <= 8; i++) push_pix(12'h300 + 12'(i));
    cyc();
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      if (i >= 2) begin
        chk("stall_tvalid", {31'd0, o_tvalid}, 32'd1);
        chk("stall_tdata", {20'd0, o_tdata}, 32'h301);
      end
    end
    chk("stall_reads_le2", {31'd0, (rd_count - rd0) <= 2}, 32'd1);
    cyc();
    i_tready = 1'b1;
    wait_drain("drain_stall");

    // Flush as the sixth pixel (x=5) returns from the FIFO.
    do_flush();
    rd0 = rd_count;
    for (int i = 1; i <= 5; i++) push_pix(12'h500 + 12'(i));
    push_raw(12'h506);
    hit = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      if (o_obuf_rd && rd_count == rd0 + 5) begin
        hit = 1'b1;
        break;
      end
    end
    chk("sixth_read_seen", {31'd0, hit}, 32'd1);
    cyc();
    i_flush = 1'b1;
    @(negedge CLK);
    chk("rd_in_flush_ret", {31'd0, o_obuf_rd}, 32'd0);
    cyc();
    i_flush = 1'b0;
    exp_x = 0;
    exp_y = 0;
    @(negedge CLK);
    chk("flush_drop_tvalid", {31'd0, o_tvalid}, 32'd0);
    push_pix(12'h5a0);
    push_pix(12'h5a1);
    wait_drain("drain_flush");

    // Enable dropped after two reads; a flush with data waiting must not read.
    exp_x = 0;
    exp_y = 0;
    i_enable = 1'b0;
    for (int i = 0; i < 8; i++) push_pix(12'h600 + 12'(i));
    cyc();
    i_enable = 1'b1;
    i_flush  = 1'b1;
    @(negedge CLK);
    chk("rd_in_flush_data", {31'd0, o_obuf_rd}, 32'd0);
    cyc();
    i_flush = 1'b0;
    rd0 = rd_count;
    cyc();
    cyc();
    i_enable = 1'b0;
    repeat (8) cyc();
    @(negedge CLK);
    chk("enable_low_reads", rd_count - rd0, 32'd2);
    chk("enable_low_delivered", sb_q.size(), 32'd6);
    chk("enable_low_tvalid", {31'd0, o_tvalid}, 32'd0);
    cyc();
    i_enable = 1'b1;
    wait_drain("drain_enable");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
